// File: rtl/tape_mem_arbiter.sv
// Shares one byte-wide, single-outstanding memory read port between two level-request
// byte readers. A read that never gets mem_ready returns 8'hFF and sets a sticky err.
module tape_mem_arbiter #(
    parameter int AW         = 25,
    parameter int TIMEOUT    = 1024,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_en,
    output logic [7:0]    a_dout,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_en,
    output logic [7:0]    b_dout,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ready,
    input  logic [7:0]    mem_dout,
    output logic          busy,
    output logic          err,
    input  logic          err_clr
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    // Counter reads TIMEOUT-2 in the cycle where it steps to TIMEOUT-1, so the
    // abandoned read completes TIMEOUT cycles after mem_rd.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    logic          r_owner;   // 0 = A, 1 = B
    logic          r_last;    // last served, same encoding
    logic [1:0]    r_mask_a;
    logic [1:0]    r_mask_b;
    logic [CW-1:0] r_cnt;
    logic          r_a_en;
    logic          r_b_en;
    logic          r_mem_rd;
    logic          r_err;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_a_dout;
    logic [7:0]    r_b_dout;

    logic          w_elig_a;
    logic          w_elig_b;
    logic          w_pick_b;
    logic          w_timeout;
    logic [7:0]    w_rdata;

    assign w_elig_a  = a_req && (r_mask_a == 2'd0);
    assign w_elig_b  = b_req && (r_mask_b == 2'd0);
    assign w_pick_b  = w_elig_b && (!w_elig_a || (FIXED_PRIO == 0 && !r_last));
    assign w_timeout = (r_cnt == CNT_LAST);
    assign w_rdata   = mem_ready ? mem_dout : 8'hFF;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_mask_a   <= 2'd0;
            r_mask_b   <= 2'd0;
            r_cnt      <= '0;
            r_a_en     <= 1'b0;
            r_b_en     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
            r_a_dout   <= 8'h00;
            r_b_dout   <= 8'h00;
        end else begin
            r_a_en   <= 1'b0;
            r_b_en   <= 1'b0;
            r_mem_rd <= 1'b0;
            if (r_mask_a != 2'd0) r_mask_a <= r_mask_a - 2'd1;
            if (r_mask_b != 2'd0) r_mask_b <= r_mask_b - 2'd1;
            if (err_clr) r_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_elig_a || w_elig_b) begin
                        r_owner    <= w_pick_b;
                        r_mem_addr <= w_pick_b ? b_addr : a_addr;
                        r_mem_rd   <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Data and strobe land together so dout is valid in the en cycle.
                    if (mem_ready || w_timeout) begin
                        if (r_owner) begin
                            r_b_dout <= w_rdata;
                            r_b_en   <= 1'b1;
                        end else begin
                            r_a_dout <= w_rdata;
                            r_a_en   <= 1'b1;
                        end
                        if (!mem_ready) r_err <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last <= r_owner;
                    // Two-cycle mask covers the requester's late drop of x_req.
                    if (r_owner) r_mask_b <= 2'd2;
                    else         r_mask_a <= 2'd2;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign a_en     = r_a_en;
    assign b_en     = r_b_en;
    assign a_dout   = r_a_dout;
    assign b_dout   = r_b_dout;
    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign err      = r_err;
    assign busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Bench for tape_mem_arbiter: a round-robin and a fixed-priority instance side by side,
// each with its own memory responder and requester emulators, checked against rule-level expectations.
module tb_tape_mem_arbiter;
    localparam int AW = 25;

    typedef struct {
        int            k;
        int            s;
        int            cyc;
        logic [AW-1:0] v;
        logic          e;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst;
    logic          err_clr;
    logic          rq   [2][2];
    logic [AW-1:0] ad   [2][2];
    logic          en   [2][2];
    logic [7:0]    dout [2][2];
    logic          mem_rd [2];
    logic [AW-1:0] mem_addr [2];
    logic          mem_ready [2];
    logic [7:0]    mem_dout [2];
    logic          busy [2];
    logic          err [2];

    int mode [2][2];
    int left [2][2];
    int tgap [2][2];
    bit tdrop [2][2];
    bit seen [2][2];
    int pend [2];
    int lat [2];
    bit resp_on [2];

    ev_t rd_q[$];
    ev_t en_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    tape_mem_arbiter #(.AW(AW), .TIMEOUT(16), .FIXED_PRIO(0)) u_rr (
        .clk_sys(clk), .reset(rst),
        .a_req(rq[0][0]), .a_addr(ad[0][0]), .a_en(en[0][0]), .a_dout(dout[0][0]),
        .b_req(rq[0][1]), .b_addr(ad[0][1]), .b_en(en[0][1]), .b_dout(dout[0][1]),
        .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .mem_ready(mem_ready[0]), .mem_dout(mem_dout[0]),
        .busy(busy[0]), .err(err[0]), .err_clr(err_clr));

    tape_mem_arbiter #(.AW(AW), .TIMEOUT(16), .FIXED_PRIO(1)) u_fp (
        .clk_sys(clk), .reset(rst),
        .a_req(rq[1][0]), .a_addr(ad[1][0]), .a_en(en[1][0]), .a_dout(dout[1][0]),
        .b_req(rq[1][1]), .b_addr(ad[1][1]), .b_en(en[1][1]), .b_dout(dout[1][1]),
        .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .mem_ready(mem_ready[1]), .mem_dout(mem_dout[1]),
        .busy(busy[1]), .err(err[1]), .err_clr(err_clr));

    // Memory content: memf(24'h000123) == 8'h5A.
    function automatic logic [7:0] memf(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'b0, a[24]} ^ 8'h78;
    endfunction

    function automatic int cnt_en(input int k, input int s);
        int m = 0;
        foreach (en_q[i]) if (en_q[i].k == k && en_q[i].s == s) m++;
        return m;
    endfunction

    function automatic ev_t get_en(input int k, input int s, input int n);
        ev_t r = '{k: -1, s: -1, cyc: -1000, v: '0, e: 1'bx};
        int m = 0;
        foreach (en_q[i]) if (en_q[i].k == k && en_q[i].s == s) begin
            if (m == n) r = en_q[i];
            m++;
        end
        return r;
    endfunction

    // s < 0 selects any requester; otherwise B addresses are the ones with bit 20 set.
    function automatic int cnt_rd(input int k, input int s);
        int m = 0;
        foreach (rd_q[i]) if (rd_q[i].k == k && (s < 0 || int'(rd_q[i].v[20]) == s)) m++;
        return m;
    endfunction

    function automatic ev_t get_rd(input int k, input int s, input int n);
        ev_t r = '{k: -1, s: -1, cyc: -2000, v: '1, e: 1'b0};
        int m = 0;
        foreach (rd_q[i]) if (rd_q[i].k == k && (s < 0 || int'(rd_q[i].v[20]) == s)) begin
            if (m == n) r = rd_q[i];
            m++;
        end
        return r;
    endfunction

    // Per-instance environment: monitor, memory responder and requester emulation.
    task automatic env(input int k);
        forever begin
            @(negedge clk);
            if (mem_rd[k]) begin
                rd_q.push_back('{k: k, s: 0, cyc: cyc, v: mem_addr[k], e: 1'b0});
                if (resp_on[k]) pend[k] = lat[k];
            end
            for (int s = 0; s < 2; s++) if (en[k][s]) begin
                en_q.push_back('{k: k, s: s, cyc: cyc, v: {17'b0, dout[k][s]}, e: err[k]});
                seen[k][s] = 1'b1;
            end
            @(posedge clk);
            #1;
            mem_ready[k] = 1'b0;
            if (pend[k] > 0) begin
                pend[k]--;
                if (pend[k] == 0) begin
                    mem_ready[k] = 1'b1;
                    mem_dout[k]  = memf(mem_addr[k]);
                end
            end
            for (int s = 0; s < 2; s++) begin
                if (seen[k][s]) begin
                    seen[k][s] = 1'b0;
                    left[k][s]--;
                    if (mode[k][s] == 1) begin
                        ad[k][s] = ad[k][s] + 1'b1;
                        if (left[k][s] <= 0) rq[k][s] = 1'b0;
                    end else if (mode[k][s] == 2) tdrop[k][s] = 1'b1;
                end else if (tdrop[k][s]) begin
                    tdrop[k][s] = 1'b0;
                    rq[k][s]    = 1'b0;
                    ad[k][s]    = ad[k][s] + 1'b1;
                    tgap[k][s]  = int'($urandom_range(0, 3));
                end else if (mode[k][s] != 0 && !rq[k][s] && left[k][s] > 0) begin
                    if (tgap[k][s] == 0) rq[k][s] = 1'b1;
                    else tgap[k][s]--;
                end
            end
        end
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 2; k++) for (int s = 0; s < 2; s++) begin
            rq[k][s] = 1'b0; mode[k][s] = 0; left[k][s] = 0;
            seen[k][s] = 1'b0; tdrop[k][s] = 1'b0; tgap[k][s] = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        clear_reqs();
        @(posedge clk); #2;
        rst = 1'b0;
        rd_q.delete();
        en_q.delete();
    endtask

    // mode 1 = hold request high, mode 2 = tape-style drop one cycle after en.
    task automatic start(input int k, input int s, input int m, input int n, input logic [AW-1:0] base);
        mode[k][s] = m; left[k][s] = n; ad[k][s] = base; tgap[k][s] = 0; tdrop[k][s] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if ({en[k][0], en[k][1], mem_rd[k], busy[k], err[k]} !== 5'b0) begin
                n_bad++; $display("FAIL reset_ctl k=%0d got=%b exp=00000", k, {en[k][0], en[k][1], mem_rd[k], busy[k], err[k]}); end
            n_cmp++; if ({mem_addr[k], dout[k][0], dout[k][1]} !== '0) begin
                n_bad++; $display("FAIL reset_data k=%0d got=%h exp=0", k, {mem_addr[k], dout[k][0], dout[k][1]}); end
        end
    endtask

    task automatic test_single_read();
        ev_t r, e;
        do_reset();
        lat[0] = 3; lat[1] = 3;
        for (int k = 0; k < 2; k++) start(k, 0, 2, 1, 25'h000123);
        repeat (12) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) start(k, 1, 2, 1, 25'h100456);
        repeat (12) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            r = get_rd(k, -1, 0);
            e = get_en(k, 0, 0);
            n_cmp++; if (cnt_rd(k, -1) !== 2) begin n_bad++; $display("FAIL single_rd_count k=%0d got=%0d exp=2", k, cnt_rd(k, -1)); end
            n_cmp++; if (r.v !== 25'h000123) begin n_bad++; $display("FAIL single_rd_addr k=%0d got=%h exp=000123", k, r.v); end
            n_cmp++; if (cnt_en(k, 0) !== 1) begin n_bad++; $display("FAIL single_a_en_count k=%0d got=%0d exp=1", k, cnt_en(k, 0)); end
            n_cmp++; if (e.v[7:0] !== 8'h5A) begin n_bad++; $display("FAIL single_a_dout k=%0d got=%h exp=5a", k, e.v[7:0]); end
            n_cmp++; if (e.cyc - r.cyc !== 4) begin n_bad++; $display("FAIL single_latency k=%0d got=%0d exp=4", k, e.cyc - r.cyc); end
            n_cmp++; if (get_rd(k, -1, 1).v !== 25'h100456) begin n_bad++; $display("FAIL single_b_addr k=%0d got=%h exp=100456", k, get_rd(k, -1, 1).v); end
            n_cmp++; if (get_en(k, 1, 0).v[7:0] !== memf(25'h100456)) begin
                n_bad++; $display("FAIL single_b_dout k=%0d got=%h exp=%h", k, get_en(k, 1, 0).v[7:0], memf(25'h100456)); end
            n_cmp++; if (dout[k][0] !== 8'h5A) begin n_bad++; $display("FAIL single_a_held k=%0d got=%h exp=5a", k, dout[k][0]); end
            n_cmp++; if (cnt_en(k, 1) !== 1 || busy[k] !== 1'b0 || err[k] !== 1'b0) begin
                n_bad++; $display("FAIL single_idle k=%0d b_en=%0d busy=%b err=%b exp=1/0/0", k, cnt_en(k, 1), busy[k], err[k]); end
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] ba, bb, ex;
        do_reset();
        lat[0] = 1; lat[1] = 1;
        ba = 25'h000200; bb = 25'h100300;
        for (int k = 0; k < 2; k++) begin start(k, 0, 1, 6, ba); start(k, 1, 1, 6, bb); end
        repeat (70) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (cnt_rd(k, -1) !== 12) begin n_bad++; $display("FAIL cont_rd_count k=%0d got=%0d exp=12", k, cnt_rd(k, -1)); end
            for (int n = 0; n < 12; n++) begin
                ex = (n % 2 == 0) ? ba + AW'(n / 2) : bb + AW'(n / 2);
                n_cmp++; if (get_rd(k, -1, n).v !== ex) begin
                    n_bad++; $display("FAIL cont_order k=%0d n=%0d got=%h exp=%h", k, n, get_rd(k, -1, n).v, ex); end
                if (n > 0) begin
                    n_cmp++; if (get_rd(k, -1, n).cyc - get_rd(k, -1, n - 1).cyc !== 4) begin
                        n_bad++; $display("FAIL cont_period k=%0d n=%0d got=%0d exp=4", k, n, get_rd(k, -1, n).cyc - get_rd(k, -1, n - 1).cyc); end
                end
            end
            for (int n = 0; n < 6; n++) begin
                n_cmp++; if (get_en(k, 0, n).v[7:0] !== memf(ba + AW'(n)) || get_en(k, 1, n).v[7:0] !== memf(bb + AW'(n))) begin
                    n_bad++; $display("FAIL cont_data k=%0d n=%0d got=%h/%h exp=%h/%h", k, n, get_en(k, 0, n).v[7:0],
                                      get_en(k, 1, n).v[7:0], memf(ba + AW'(n)), memf(bb + AW'(n))); end
                // B is granted in A's first masked cycle: B's mem_rd is 2 cycles after a_en.
                n_cmp++; if (get_rd(k, 1, n).cyc - get_en(k, 0, n).cyc !== 2) begin
                    n_bad++; $display("FAIL cont_mask_window k=%0d n=%0d got=%0d exp=2", k, n, get_rd(k, 1, n).cyc - get_en(k, 0, n).cyc); end
            end
        end
    endtask

    task automatic test_prio_tie();
        do_reset();
        lat[0] = 2; lat[1] = 2;
        for (int k = 0; k < 2; k++) start(k, 0, 2, 1, 25'h000400);
        repeat (15) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin start(k, 0, 2, 1, 25'h000401); start(k, 1, 2, 1, 25'h100500); end
        repeat (25) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (cnt_rd(0, -1) !== 3 || cnt_rd(1, -1) !== 3) begin
            n_bad++; $display("FAIL tie_count got=%0d/%0d exp=3/3", cnt_rd(0, -1), cnt_rd(1, -1)); end
        n_cmp++; if (get_rd(0, -1, 1).v !== 25'h100500) begin n_bad++; $display("FAIL tie_rr got=%h exp=100500", get_rd(0, -1, 1).v); end
        n_cmp++; if (get_rd(1, -1, 1).v !== 25'h000401) begin n_bad++; $display("FAIL tie_fixed got=%h exp=000401", get_rd(1, -1, 1).v); end
    endtask

    task automatic test_random_tape();
        logic [AW-1:0] base [2];
        ev_t r, e;
        do_reset();
        lat[0] = int'($urandom_range(1, 6));
        lat[1] = lat[0];
        base[0] = AW'($urandom_range(0, 16'hFFF0));
        base[1] = 25'h100000 | AW'($urandom_range(0, 16'hFFF0));
        for (int k = 0; k < 2; k++) for (int s = 0; s < 2; s++) start(k, s, 2, 8, base[s]);
        repeat (300) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) for (int s = 0; s < 2; s++) begin
            n_cmp++; if (cnt_rd(k, s) !== 8 || cnt_en(k, s) !== 8) begin
                n_bad++; $display("FAIL tape_counts k=%0d s=%0d rd=%0d en=%0d exp=8", k, s, cnt_rd(k, s), cnt_en(k, s)); end
            for (int n = 0; n < 8; n++) begin
                r = get_rd(k, s, n);
                e = get_en(k, s, n);
                n_cmp++; if (r.v !== base[s] + AW'(n)) begin
                    n_bad++; $display("FAIL tape_addr k=%0d s=%0d n=%0d got=%h exp=%h", k, s, n, r.v, base[s] + AW'(n)); end
                n_cmp++; if (e.v[7:0] !== memf(base[s] + AW'(n)) || e.e !== 1'b0) begin
                    n_bad++; $display("FAIL tape_data k=%0d s=%0d n=%0d got=%h err=%b exp=%h", k, s, n, e.v[7:0], e.e, memf(base[s] + AW'(n))); end
                n_cmp++; if (e.cyc - r.cyc !== lat[k] + 1) begin
                    n_bad++; $display("FAIL tape_latency k=%0d s=%0d n=%0d got=%0d exp=%0d", k, s, n, e.cyc - r.cyc, lat[k] + 1); end
            end
        end
    endtask

    task automatic one_read(input logic [AW-1:0] a, input int l, input bit on);
        do_reset();
        lat[0] = l; lat[1] = l; resp_on[0] = on; resp_on[1] = on;
        for (int k = 0; k < 2; k++) start(k, 0, 2, 1, a);
        repeat (25) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        one_read(25'h000600, 1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (cnt_rd(k, -1) !== 1 || cnt_en(k, 0) !== 1) begin
                n_bad++; $display("FAIL to_counts k=%0d rd=%0d en=%0d exp=1", k, cnt_rd(k, -1), cnt_en(k, 0)); end
            n_cmp++; if (get_en(k, 0, 0).cyc - get_rd(k, -1, 0).cyc !== 16) begin
                n_bad++; $display("FAIL to_latency k=%0d got=%0d exp=16", k, get_en(k, 0, 0).cyc - get_rd(k, -1, 0).cyc); end
            n_cmp++; if (get_en(k, 0, 0).v[7:0] !== 8'hFF || get_en(k, 0, 0).e !== 1'b1) begin
                n_bad++; $display("FAIL to_data k=%0d got=%h err=%b exp=ff/1", k, get_en(k, 0, 0).v[7:0], get_en(k, 0, 0).e); end
            n_cmp++; if (err[k] !== 1'b1) begin n_bad++; $display("FAIL to_sticky k=%0d got=%b exp=1", k, err[k]); end
        end
        @(posedge clk); #2; err_clr = 1'b1;
        @(posedge clk); #2; err_clr = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (err[k] !== 1'b0) begin n_bad++; $display("FAIL to_clear k=%0d got=%b exp=0", k, err[k]); end
        end
        // Clear held through a timeout: the set takes effect first.
        err_clr = 1'b1;
        one_read(25'h000601, 1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (get_en(k, 0, 0).e !== 1'b1 || err[k] !== 1'b0) begin
                n_bad++; $display("FAIL to_set_wins k=%0d at_en=%b later=%b exp=1/0", k, get_en(k, 0, 0).e, err[k]); end
        end
        err_clr = 1'b0;
        resp_on[0] = 1'b1; resp_on[1] = 1'b1;
    endtask

    task automatic test_ready_edge();
        one_read(25'h000700, 15, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (get_en(k, 0, 0).v[7:0] !== memf(25'h000700) || get_en(k, 0, 0).e !== 1'b0 || err[k] !== 1'b0) begin
                n_bad++; $display("FAIL edge_ready_wins k=%0d got=%h err=%b exp=%h/0", k, get_en(k, 0, 0).v[7:0], err[k], memf(25'h000700)); end
            n_cmp++; if (get_en(k, 0, 0).cyc - get_rd(k, -1, 0).cyc !== 16) begin
                n_bad++; $display("FAIL edge_ready_lat k=%0d got=%0d exp=16", k, get_en(k, 0, 0).cyc - get_rd(k, -1, 0).cyc); end
        end
        one_read(25'h000701, 16, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (get_en(k, 0, 0).v[7:0] !== 8'hFF || err[k] !== 1'b1 || cnt_en(k, 0) !== 1 || cnt_rd(k, -1) !== 1) begin
                n_bad++; $display("FAIL edge_late_ready k=%0d got=%h err=%b en=%0d rd=%0d exp=ff/1/1/1", k,
                                  get_en(k, 0, 0).v[7:0], err[k], cnt_en(k, 0), cnt_rd(k, -1)); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int t;
        do_reset();
        lat[0] = 6; lat[1] = 6;
        for (int k = 0; k < 2; k++) start(k, 0, 2, 1, 25'h000800);
        t = 0;
        while (cnt_rd(0, -1) == 0 && t < 20) begin @(negedge clk); t++; end
        n_cmp++; if (cnt_rd(0, -1) == 0) begin n_bad++; $display("FAIL rstw_no_read got=0 exp=1"); end
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        clear_reqs();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if ({en[k][0], en[k][1], mem_rd[k], busy[k], err[k], mem_addr[k], dout[k][0], dout[k][1]} !== '0) begin
                n_bad++; $display("FAIL rstw_async k=%0d busy=%b addr=%h exp=0", k, busy[k], mem_addr[k]); end
        end
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (cnt_en(k, 0) + cnt_en(k, 1) !== 0 || busy[k] !== 1'b0 || mem_addr[k] !== '0) begin
                n_bad++; $display("FAIL rstw_ignored k=%0d en=%0d busy=%b addr=%h exp=0", k, cnt_en(k, 0) + cnt_en(k, 1), busy[k], mem_addr[k]); end
        end
        @(posedge clk); #2;
        lat[0] = 2; lat[1] = 2;
        for (int k = 0; k < 2; k++) start(k, 0, 2, 1, 25'h000801);
        repeat (12) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (cnt_rd(k, -1) !== 2 || cnt_en(k, 0) !== 1 || get_en(k, 0, 0).v[7:0] !== memf(25'h000801)) begin
                n_bad++; $display("FAIL rstw_fresh k=%0d rd=%0d en=%0d got=%h exp=2/1/%h", k, cnt_rd(k, -1), cnt_en(k, 0),
                                  get_en(k, 0, 0).v[7:0], memf(25'h000801)); end
        end
    endtask

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        clear_reqs();
        for (int k = 0; k < 2; k++) begin
            ad[k][0] = '0; ad[k][1] = '0;
            pend[k] = 0; lat[k] = 1; resp_on[k] = 1'b1;
            mem_ready[k] = 1'b0; mem_dout[k] = 8'h00;
        end
        fork
            env(0);
            env(1);
        join_none
        test_reset();
        test_single_read();
        test_contention();
        test_prio_tie();
        test_random_tape();
        test_timeout();
        test_ready_edge();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tape_mem_arbiter.md
Name: tape_mem_arbiter

Overview:
- Shares one byte-wide, single-outstanding-read memory port between two byte-stream readers.
- Requester A is the tape player's data fetch. Requester B is a second loader, such as the snapshot or ROM loader.
- Each requester uses a level request with a rising-edge completion strobe, the same handshake the tape reader already consumes.
- The block sequences each memory read, returns the data, and guards against a memory that never answers.

Parameters:
AW, 25, address width of requesters and memory port
TIMEOUT, 1024, clk_sys cycles to wait for mem_ready before abandoning a read (must be >= 2)
FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins ties

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
a_req  in  1  requester A wants a byte; level, held until served
a_addr  in  AW  requester A byte address; sampled at grant
a_en  out  1  1-cycle completion strobe to A
a_dout  out  8  data for A; valid from a_en cycle, stable until A's next a_en
b_req  in  1  requester B level request
b_addr  in  AW  requester B byte address
b_en  out  1  1-cycle completion strobe to B
b_dout  out  8  data for B; same rules as a_dout
mem_rd  out  1  1-cycle read strobe to memory
mem_addr  out  AW  read address; stable from mem_rd until transaction ends
mem_ready  in  1  1-cycle strobe: mem_dout valid
mem_dout  in  8  memory read data
busy  out  1  high in any state other than IDLE
err  out  1  sticky timeout flag
err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async assert): state IDLE, all outputs 0 (a_en, b_en, mem_rd, mem_addr, a_dout, b_dout, busy, err), owner = A, last-served = B, both masks clear.
- Reset mid-transaction: the read is abandoned with no strobe to either requester. A late mem_ready after reset release is ignored (state is IDLE).
- Eligibility: X is eligible when x_req=1 and mask_X=0.
- Mask: mask_X is set in the DONE cycle for X and cleared 2 cycles later. This covers the requester's one-cycle delay in dropping x_req after x_en.
- IDLE:
  - If no requester is eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible and FIXED_PRIO=1, grant A. If FIXED_PRIO=0, grant the one not in last-served.
  - On grant: latch owner, set mem_addr <= owner addr, go to ISSUE.
- ISSUE: mem_rd=1 for exactly this cycle. Clear wait counter. Go to WAIT. mem_ready is not sampled in ISSUE.
- WAIT:
  - Counter increments each cycle.
  - mem_ready=1: latch mem_dout into a holding register, go to DONE.
  - Otherwise, counter reaching TIMEOUT-1: holding register = 8'hFF, err <= 1, go to DONE.
  - If mem_ready and timeout occur in the same cycle, mem_ready wins and err is not set.
- DONE:
  - Owner's dout <= holding register; owner's en=1 for this cycle only.
  - last-served <= owner; set mask_owner; go to IDLE.
  - The other requester's dout and en are untouched.
- Latency: grant seen in IDLE at cycle 0, mem_rd at cycle 1, mem_ready earliest at cycle 2, x_en at cycle 3. Minimum 4 cycles per byte, so back-to-back reads of one requester are ≥4 cycles apart.
- A requester dropping x_req after grant: the transaction still completes and x_en still pulses. It is the requester's duty to ignore it.
- Stray mem_ready in IDLE, ISSUE or DONE: ignored.
- err_clr and a timeout in the same cycle: set wins.
- The wait counter is sized clog2(TIMEOUT)+1 bits and never wraps (it exits at TIMEOUT-1).
- All x_en/mem_rd outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Single A read: a_addr=0x000123, a_req=1; memory returns 0x5A 3 cycles after mem_rd.
  -> mem_rd one cycle with mem_addr=0x000123; a_en one cycle after mem_ready; a_dout=0x5A held; b_en never pulses.
- Round-robin contention, FIXED_PRIO=0: a_req and b_req held high, memory latency 1.
  -> grants alternate A,B,A,B; each x_en ≥4 cycles apart; each requester's data matches its address pattern.
- Fixed priority, FIXED_PRIO=1: same stimulus.
  -> A served every cycle it is eligible; B granted only during A's 2-cycle mask window.
- Timeout, TIMEOUT=16: memory never asserts mem_ready.
  -> a_en pulses 16 cycles after mem_rd with a_dout=0xFF, err=1; err_clr pulse -> err=0.
- Reset mid-WAIT: assert reset 2 cycles after mem_rd, release, then send mem_ready.
  -> all outputs 0, no a_en or b_en; next a_req starts a fresh read normally.
- Mask/edge handshake: emulate tape behaviour where a_req drops 1 cycle after a_en.
  -> exactly one mem_rd per a_en; no duplicate read of the same address.
